// File: rtl/addsub_entry_ctrl.sv
// Operand-entry and result-capture stage around a 4-bit add/subtract unit.
// A debounced push-button steps the entry FSM: capture A, capture B plus the
// add/sub select, spend one cycle letting the adder settle and latch its
// outputs, then hold the result until the next press.
module addsub_entry_ctrl #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       op_sw,
  input  logic       btn,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       control,
  input  logic [3:0] res_in,
  input  logic       carry_in,
  input  logic       zf_in,
  input  logic       of_in,
  output logic [3:0] res_q,
  output logic       carry_q,
  output logic       zf_q,
  output logic       of_q,
  output logic [1:0] state_o,
  output logic       done
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES) + 1;
  // Counter value at which one more mismatching cycle completes the window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam logic [1:0] S_A    = 2'b00;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_CALC = 2'b10;
  localparam logic [1:0] S_SHOW = 2'b11;

  logic             btn_m;
  logic             btn_s;
  logic             deb;
  logic             deb_prev;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic [1:0]       state;
  logic [1:0]       state_next;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  // Debounce: deb follows btn_s only after DEB_CYCLES consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (btn_s == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= btn_s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy of deb for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_prev <= 1'b0;
    end else begin
      deb_prev <= deb;
    end
  end

  // One-cycle pulse in the cycle after deb rises; release is ignored.
  assign press = deb & ~deb_prev;

  // Next-state decode; S_CALC always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      S_A:     if (press) state_next = S_B;
      S_B:     if (press) state_next = S_CALC;
      S_CALC:  state_next = S_SHOW;
      S_SHOW:  if (press) state_next = S_A;
      default: state_next = S_A;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_A;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture; switches matter only on the press cycle of the matching state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a       <= 4'h0;
      b       <= 4'h0;
      control <= 1'b0;
    end else begin
      if (state == S_A && press) begin
        a <= sw;
      end
      if (state == S_B && press) begin
        b       <= sw;
        control <= op_sw;
      end
    end
  end

  // Result capture at the end of S_CALC, by which time the adder has settled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q   <= 4'h0;
      carry_q <= 1'b0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else if (state == S_CALC) begin
      res_q   <= res_in;
      carry_q <= carry_in;
      zf_q    <= zf_in;
      of_q    <= of_in;
    end
  end

  // Result-valid flag: set on leaving S_CALC, cleared by the press that leaves S_SHOW.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (state == S_CALC) begin
      done <= 1'b1;
    end else if (state == S_SHOW && press) begin
      done <= 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_addsub_entry_ctrl.sv
// Bench for addsub_entry_ctrl with a behavioural 4-bit add/sub unit and a
// result scoreboard fed when operand B is entered.
module tb_addsub_entry_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned HOLD = DEB + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       op_sw = 1'b0;
  logic       btn = 1'b0;
  logic [3:0] a, b;
  logic       control;
  logic [3:0] res_in;
  logic       carry_in, zf_in, of_in;
  logic [3:0] res_q;
  logic       carry_q, zf_q, of_q;
  logic [1:0] state_o;
  logic       done;

  int n_tests = 0;
  int n_fail = 0;

  // Expected {res, carry, zf, of}
  logic [6:0] exp_q[$];
  logic [6:0] last_exp;
  logic [3:0] a_exp;

  always #5 clk = ~clk;

  addsub_entry_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .op_sw(op_sw), .btn(btn),
    .a(a), .b(b), .control(control),
    .res_in(res_in), .carry_in(carry_in), .zf_in(zf_in), .of_in(of_in),
    .res_q(res_q), .carry_q(carry_q), .zf_q(zf_q), .of_q(of_q),
    .state_o(state_o), .done(done)
  );

  // Combinational adder stand-in (subtract = a + ~b + 1, carry = no borrow).
  always_comb begin
    logic [4:0] sum;
    logic [3:0] bb;
    bb       = control ? ~b : b;
    sum      = {1'b0, a} + {1'b0, bb} + {4'b0, control};
    res_in   = sum[3:0];
    carry_in = sum[4];
    zf_in    = (sum[3:0] == 4'h0);
    of_in    = (a[3] == bb[3]) && (sum[3] != a[3]);
  end

  function automatic logic [6:0] model(input logic [3:0] x, input logic [3:0] y,
                                       input logic sub);
    logic [4:0] s;
    logic [3:0] yy;
    yy = sub ? ~y : y;
    s  = {1'b0, x} + {1'b0, yy} + {4'b0, sub};
    return {s[3:0], s[4], s[3:0] == 4'h0, (x[3] == yy[3]) && (s[3] != x[3])};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_btn();
    btn = 1'b1;
    cycles(HOLD);
    btn = 1'b0;
    cycles(HOLD);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  task automatic run_calc(input string tag, input logic [3:0] x, input logic [3:0] y,
                          input logic sub);
    logic [6:0] e;
    int waited;
    sw = x;
    press_btn();
    check_eq({tag, "_stateB"}, 8'(state_o), 8'h1);
    check_eq({tag, "_a"}, 8'(a), 8'(x));
    sw    = y;
    op_sw = sub;
    exp_q.push_back(model(x, y, sub));
    press_btn();
    waited = 0;
    while (!done && waited < 50) begin
      cycles(1);
      waited++;
    end
    check_eq({tag, "_done"}, 8'(done), 8'h1);
    e = exp_q.pop_front();
    last_exp = e;
    check_eq({tag, "_res"}, 8'(res_q), 8'(e[6:3]));
    check_eq({tag, "_carry"}, 8'(carry_q), 8'(e[2]));
    check_eq({tag, "_zf"}, 8'(zf_q), 8'(e[1]));
    check_eq({tag, "_of"}, 8'(of_q), 8'(e[0]));
    check_eq({tag, "_state"}, 8'(state_o), 8'h3);
    check_eq({tag, "_ctrl"}, 8'(control), 8'(sub));
  endtask

  initial begin
    do_reset();
    check_eq("rst_state", 8'(state_o), 8'h0);
    check_eq("rst_a", 8'(a), 8'h0);
    check_eq("rst_b", 8'(b), 8'h0);
    check_eq("rst_done", 8'(done), 8'h0);
    check_eq("rst_res", 8'({res_q, carry_q, zf_q, of_q}), 8'h0);

    run_calc("add_ovf", 4'd3, 4'd5, 1'b0);
    check_eq("add_ovf_lit", 8'({res_q, carry_q, zf_q, of_q}), 8'b0100_0001);
    press_btn();
    check_eq("ret_state", 8'(state_o), 8'h0);
    check_eq("ret_done", 8'(done), 8'h0);

    run_calc("sub_zero", 4'd5, 4'd5, 1'b1);
    press_btn();
    run_calc("sub_ovf", 4'd8, 4'd1, 1'b1);
    press_btn();
    run_calc("add_wrap", 4'd15, 4'd2, 1'b0);

    // Hold in S_SHOW: switches move, outputs do not.
    a_exp = 4'd15;
    for (int i = 0; i < 6; i++) begin
      sw    = 4'($urandom_range(0, 15));
      op_sw = ~op_sw;
      cycles(3);
    end
    check_eq("hold_state", 8'(state_o), 8'h3);
    check_eq("hold_res", 8'(res_q), 8'(last_exp[6:3]));
    check_eq("hold_a", 8'(a), 8'(a_exp));
    check_eq("hold_done", 8'(done), 8'h1);
    press_btn();
    check_eq("back_state", 8'(state_o), 8'h0);
    check_eq("back_done", 8'(done), 8'h0);
    check_eq("back_res", 8'(res_q), 8'(last_exp[6:3]));

    // Glitch one cycle short of the debounce window.
    sw  = 4'd6;
    btn = 1'b1;
    cycles(DEB - 1);
    btn = 1'b0;
    cycles(HOLD);
    check_eq("glitch_state", 8'(state_o), 8'h0);
    check_eq("glitch_a", 8'(a), 8'(a_exp));
    press_btn();
    check_eq("one_press_state", 8'(state_o), 8'h1);
    check_eq("one_press_a", 8'(a), 8'h6);

    // Reset mid-entry discards the partial operand.
    do_reset();
    sw = 4'd9;
    press_btn();
    check_eq("mid_state", 8'(state_o), 8'h1);
    check_eq("mid_a", 8'(a), 8'h9);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    check_eq("mid_rst_state", 8'(state_o), 8'h0);
    check_eq("mid_rst_a", 8'(a), 8'h0);
    check_eq("mid_rst_done", 8'(done), 8'h0);
    check_eq("mid_rst_res", 8'(res_q), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
